// File: rtl/click_pkg.sv
// Shared types and helpers for the click-selector: debounce FSM states and
// a width helper that never returns zero.
package click_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMING    = 2'd1,
    HELD      = 2'd2,
    LONG_DONE = 2'd3
  } db_state_e;

  function automatic int clog2_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/click_debounce.sv
// One button: 2-FF synchronizer, debounce, one-cycle press pulse on a
// debounced rising edge, and one long pulse per sufficiently long hold.
module click_debounce
  import click_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LONG_CYCLES     = 1000
) (
  input  logic      clk,
  input  logic      i_reset,
  input  logic      btn_i,
  output logic      press_o,
  output logic      long_o,
  output db_state_e state_o
);

  localparam int DB_W   = clog2_w(DEBOUNCE_CYCLES);
  localparam int HOLD_W = clog2_w(LONG_CYCLES + 1);

  logic              sync1_q, sync2_q;
  logic [DB_W-1:0]   cnt_q, cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  db_state_e         state_q, state_d;
  logic              press_q, press_d;
  logic              long_q, long_d;
  logic              db, accept;

  // Debounced level is implied by the state: high in HELD and LONG_DONE.
  assign db     = (state_q == HELD) || (state_q == LONG_DONE);
  assign accept = (sync2_q != db) && (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (i_reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      hold_q  <= '0;
      state_q <= IDLE;
      press_q <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      state_q <= state_d;
      press_q <= press_d;
      long_q  <= long_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (accept) state_d = HELD;
                 else if (sync2_q) state_d = ARMING;
      ARMING:    if (accept) state_d = HELD;
                 else if (!sync2_q) state_d = IDLE;
      HELD:      if (accept) state_d = IDLE;
                 else if (hold_q == HOLD_W'(LONG_CYCLES - 1)) state_d = LONG_DONE;
      LONG_DONE: if (accept) state_d = IDLE;
      default:   state_d = IDLE;
    endcase

    cnt_d   = ((sync2_q == db) || accept) ? '0 : cnt_q + 1'b1;
    // hold_q counts debounced-high cycles, the first one included.
    hold_d  = (state_d == HELD) ? ((state_q == HELD) ? hold_q + 1'b1 : HOLD_W'(1)) : '0;
    press_d = ((state_q == IDLE) || (state_q == ARMING)) && accept;
    long_d  = (state_q == HELD) && (state_d == LONG_DONE);
  end

  always_comb begin
    press_o = press_q;
    long_o  = long_q;
    state_o = state_q;
  end

endmodule

// File: rtl/click_sel_mux.sv
// Up/down button driven input selector: debounced presses step a registered
// index (wrapping or saturating), a long press returns it to HOME_SEL.
module click_sel_mux
  import click_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int N_STATES        = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LONG_CYCLES     = 1000,
  parameter int WRAP            = 1,
  parameter int HOME_SEL        = 0
) (
  input  logic                        clk,
  input  logic                        i_reset,
  input  logic                        i_up,
  input  logic                        i_dn,
  input  logic [WIDTH-1:0]            i_x [N_STATES],
  output logic [WIDTH-1:0]            o_x,
  output logic [$clog2(N_STATES)-1:0] o_sel,
  output logic                        o_changed,
  output db_state_e                   o_up_state,
  output db_state_e                   o_dn_state
);

  localparam int SEL_W = clog2_w(N_STATES);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(N_STATES - 1);
  localparam logic [SEL_W-1:0] HOME = SEL_W'(HOME_SEL);

  logic             up_press, up_long, dn_press, dn_long;
  logic [SEL_W-1:0] sel_q, sel_d, inc, dec;
  logic             changed_q, changed_d;

  click_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .LONG_CYCLES    (LONG_CYCLES)
  ) u_up (
    .clk    (clk),
    .i_reset(i_reset),
    .btn_i  (i_up),
    .press_o(up_press),
    .long_o (up_long),
    .state_o(o_up_state)
  );

  click_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .LONG_CYCLES    (LONG_CYCLES)
  ) u_dn (
    .clk    (clk),
    .i_reset(i_reset),
    .btn_i  (i_dn),
    .press_o(dn_press),
    .long_o (dn_long),
    .state_o(o_dn_state)
  );

  always_comb begin
    inc = (sel_q == LAST) ? ((WRAP != 0) ? '0 : sel_q) : sel_q + 1'b1;
    dec = (sel_q == '0) ? ((WRAP != 0) ? LAST : sel_q) : sel_q - 1'b1;
    // Long press wins; opposing presses in the same cycle cancel.
    if (up_long || dn_long)        sel_d = HOME;
    else if (up_press && !dn_press) sel_d = inc;
    else if (dn_press && !up_press) sel_d = dec;
    else                            sel_d = sel_q;
    changed_d = (sel_d != sel_q);
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      sel_q     <= HOME;
      changed_q <= 1'b0;
    end else begin
      sel_q     <= sel_d;
      changed_q <= changed_d;
    end
  end

  assign o_sel     = sel_q;
  assign o_changed = changed_q;
  assign o_x       = i_x[sel_q];

endmodule

// File: tb/tb_click_sel_mux.sv
// Directed bench: four selector configurations share the button stimulus;
// each index change is checked against a per-instance expected queue.
module tb_click_sel_mux;
  import click_pkg::*;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic i_reset, i_up, i_dn;
  logic [W-1:0] x4 [4];
  logic [W-1:0] x3 [3];

  logic [1:0]   sel_w [4];
  logic         chg_w [4];
  logic [W-1:0] x_w   [4];
  db_state_e    up_st [4];
  db_state_e    dn_st [4];

  // u0: N=4 wrap; u1: N=3 wrap; u2: N=3 saturate; u3: N=4 wrap, LONG_CYCLES=10
  click_sel_mux #(.WIDTH(W), .N_STATES(4), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(1000), .WRAP(1), .HOME_SEL(0)) u0 (
    .clk(clk), .i_reset(i_reset), .i_up(i_up), .i_dn(i_dn), .i_x(x4),
    .o_x(x_w[0]), .o_sel(sel_w[0]), .o_changed(chg_w[0]), .o_up_state(up_st[0]), .o_dn_state(dn_st[0]));
  click_sel_mux #(.WIDTH(W), .N_STATES(3), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(1000), .WRAP(1), .HOME_SEL(0)) u1 (
    .clk(clk), .i_reset(i_reset), .i_up(i_up), .i_dn(i_dn), .i_x(x3),
    .o_x(x_w[1]), .o_sel(sel_w[1]), .o_changed(chg_w[1]), .o_up_state(up_st[1]), .o_dn_state(dn_st[1]));
  click_sel_mux #(.WIDTH(W), .N_STATES(3), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(1000), .WRAP(0), .HOME_SEL(0)) u2 (
    .clk(clk), .i_reset(i_reset), .i_up(i_up), .i_dn(i_dn), .i_x(x3),
    .o_x(x_w[2]), .o_sel(sel_w[2]), .o_changed(chg_w[2]), .o_up_state(up_st[2]), .o_dn_state(dn_st[2]));
  click_sel_mux #(.WIDTH(W), .N_STATES(4), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(10), .WRAP(1), .HOME_SEL(0)) u3 (
    .clk(clk), .i_reset(i_reset), .i_up(i_up), .i_dn(i_dn), .i_x(x4),
    .o_x(x_w[3]), .o_sel(sel_w[3]), .o_changed(chg_w[3]), .o_up_state(up_st[3]), .o_dn_state(dn_st[3]));

  // ---------------- scoreboard ----------------
  logic [1:0] exp_q0[$], exp_q1[$], exp_q2[$], exp_q3[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic push_exp(input int id, input logic [1:0] v);
    case (id)
      0: exp_q0.push_back(v);
      1: exp_q1.push_back(v);
      2: exp_q2.push_back(v);
      default: exp_q3.push_back(v);
    endcase
  endtask

  // Monitor: every o_changed pulse consumes one expected index.
  logic [1:0] mon_e;
  bit         mon_have;
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (chg_w[i]) begin
        mon_have = 1'b0;
        mon_e    = '0;
        case (i)
          0: if (exp_q0.size() > 0) begin mon_e = exp_q0.pop_front(); mon_have = 1'b1; end
          1: if (exp_q1.size() > 0) begin mon_e = exp_q1.pop_front(); mon_have = 1'b1; end
          2: if (exp_q2.size() > 0) begin mon_e = exp_q2.pop_front(); mon_have = 1'b1; end
          default: if (exp_q3.size() > 0) begin mon_e = exp_q3.pop_front(); mon_have = 1'b1; end
        endcase
        if (!mon_have) begin
          n_vec++;
          n_err++;
          $display("FAIL u%0d unexpected o_changed: o_sel=%0d, no change expected", i, sel_w[i]);
        end else begin
          check($sformatf("u%0d o_sel on change", i), int'(sel_w[i]), int'(mon_e));
          check($sformatf("u%0d o_x on change", i), int'(x_w[i]), 8'hA0 + int'(mon_e));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    tick(2);
    i_reset = 1'b0;
  endtask

  task automatic press(input logic up, input logic dn, input int hold);
    i_up = up;
    i_dn = dn;
    tick(hold);
    i_up = 1'b0;
    i_dn = 1'b0;
    tick(14);
  endtask

  task automatic chk_sel(input string tag, input int e0, input int e1, input int e2, input int e3);
    check({tag, " u0 o_sel"}, int'(sel_w[0]), e0);
    check({tag, " u1 o_sel"}, int'(sel_w[1]), e1);
    check({tag, " u2 o_sel"}, int'(sel_w[2]), e2);
    check({tag, " u3 o_sel"}, int'(sel_w[3]), e3);
  endtask

  task automatic chk_chg(input string tag, input int c);
    for (int i = 0; i < 4; i++)
      check($sformatf("%s u%0d o_changed", tag, i), int'(chg_w[i]), c);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int k = 0; k < 4; k++) x4[k] = W'(8'hA0 + k);
    for (int k = 0; k < 3; k++) x3[k] = W'(8'hA0 + k);
    i_reset = 1'b1;
    i_up    = 1'b0;
    i_dn    = 1'b0;
    tick(3);
    chk_sel("reset", 0, 0, 0, 0);
    chk_chg("reset", 0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("reset u%0d up state", i), int'(up_st[i]), int'(IDLE));
      check($sformatf("reset u%0d dn state", i), int'(dn_st[i]), int'(IDLE));
    end
    i_reset = 1'b0;

    // Single press held 20 cycles; u3 (LONG=10) also long-presses home.
    for (int i = 0; i < 4; i++) push_exp(i, 2'd1);
    push_exp(3, 2'd0);
    i_up = 1'b1;
    tick(6);
    chk_sel("single edge6", 0, 0, 0, 0);
    tick(1);
    chk_sel("single edge7", 1, 1, 1, 1);
    chk_chg("single edge7", 1);
    tick(1);
    chk_chg("single edge8", 0);
    tick(12);
    i_up = 1'b0;
    tick(14);
    chk_sel("single end", 1, 1, 1, 0);

    // Glitch of 3 cycles is rejected.
    i_up = 1'b1;
    tick(3);
    i_up = 1'b0;
    tick(12);
    chk_sel("glitch", 1, 1, 1, 0);

    // Four up presses from 0: wrap vs saturate.
    do_reset();
    chk_sel("reset2", 0, 0, 0, 0);
    push_exp(0, 2'd1); push_exp(0, 2'd2); push_exp(0, 2'd3); push_exp(0, 2'd0);
    push_exp(1, 2'd1); push_exp(1, 2'd2); push_exp(1, 2'd0); push_exp(1, 2'd1);
    push_exp(2, 2'd1); push_exp(2, 2'd2);
    push_exp(3, 2'd1); push_exp(3, 2'd2); push_exp(3, 2'd3); push_exp(3, 2'd0);
    for (int p = 0; p < 4; p++) press(1'b1, 1'b0, 8);
    chk_sel("up x4", 0, 1, 2, 0);

    // Down press at index 0.
    do_reset();
    push_exp(0, 2'd3); push_exp(1, 2'd2); push_exp(3, 2'd3);
    press(1'b0, 1'b1, 8);
    chk_sel("dn at 0", 3, 2, 0, 3);

    // Simultaneous up and down: no change.
    press(1'b1, 1'b1, 8);
    chk_sel("simultaneous", 3, 2, 0, 3);

    // Bring u3 to 2, then long down press: 2 -> 1 -> home.
    push_exp(0, 2'd2); push_exp(1, 2'd1); push_exp(3, 2'd2);
    press(1'b0, 1'b1, 8);
    chk_sel("dn to 2", 2, 1, 0, 2);
    push_exp(0, 2'd1); push_exp(1, 2'd0); push_exp(3, 2'd1); push_exp(3, 2'd0);
    press(1'b0, 1'b1, 30);
    chk_sel("long press", 1, 0, 0, 0);

    // Reset two debounce cycles into a hold; press is re-accepted afterwards.
    for (int i = 0; i < 4; i++) push_exp(i, 2'd1);
    i_up = 1'b1;
    tick(4);
    i_reset = 1'b1;
    tick(1);
    i_reset = 1'b0;
    chk_sel("mid-hold reset", 0, 0, 0, 0);
    tick(6);
    chk_sel("re-press edge6", 0, 0, 0, 0);
    tick(1);
    chk_sel("re-press edge7", 1, 1, 1, 1);
    chk_chg("re-press edge7", 1);
    tick(1);
    i_up = 1'b0;
    tick(14);
    chk_sel("re-press end", 1, 1, 1, 1);

    check("u0 pending expected", exp_q0.size(), 0);
    check("u1 pending expected", exp_q1.size(), 0);
    check("u2 pending expected", exp_q2.size(), 0);
    check("u3 pending expected", exp_q3.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
